// File: rtl/im_pkg.sv
// Shared types for the instruction-memory read path: response codes and word width.
package im_pkg;

  localparam int unsigned IM_WORD_W = 32;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } resp_e;

endpackage

// File: rtl/im_rom_responder_if.sv
// Read-only AXI-Lite style bus (AR and R channels) between a fetch unit and the ROM.
interface im_rom_responder_if #(
  parameter int unsigned XLEN = 32
);
  import im_pkg::*;

  logic            arvalid;
  logic            arready;
  logic [XLEN-1:0] araddr;
  logic [2:0]      arprot;
  logic            rvalid;
  logic            rready;
  logic [XLEN-1:0] rdata;
  resp_e           rresp;

  modport master (
    output arvalid, araddr, arprot, rready,
    input  arready, rvalid, rdata, rresp
  );

  modport slave (
    input  arvalid, araddr, arprot, rready,
    output arready, rvalid, rdata, rresp
  );

endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered pointers and count; head_o shows the oldest entry.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [WIDTH-1:0] head_o
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] store_q [DEPTH];
  logic [PW-1:0]    wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push_s, do_pop_s;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == CW'(0));
  assign head_o  = store_q[rd_q];

  always_comb begin
    do_push_s = push_i && !full_o;
    do_pop_s  = pop_i && !empty_o;
    wr_d      = wr_q;
    rd_d      = rd_q;
    count_d   = count_q;
    if (do_push_s) wr_d = (wr_q == PW'(DEPTH - 1)) ? PW'(0) : wr_q + PW'(1);
    else           wr_d = wr_q;
    if (do_pop_s) rd_d = (rd_q == PW'(DEPTH - 1)) ? PW'(0) : rd_q + PW'(1);
    else          rd_d = rd_q;
    if (do_push_s && !do_pop_s)      count_d = count_q + CW'(1);
    else if (!do_push_s && do_pop_s) count_d = count_q - CW'(1);
    else                             count_d = count_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q    <= PW'(0);
      rd_q    <= PW'(0);
      count_q <= CW'(0);
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
    end
  end

  // Storage is left unreset so it can map onto distributed RAM.
  always_ff @(posedge clk) begin
    if (do_push_s) store_q[wr_q] <= data_i;
  end

endmodule

// File: rtl/im_rom_responder.sv
// Instruction ROM behind an AR/R read channel: two-stage read pipeline feeding a
// response FIFO, with credit flow control so the FIFO can never overflow.
module im_rom_responder
  import im_pkg::*;
#(
  parameter int unsigned     XLEN        = 32,
  parameter int unsigned     DEPTH_WORDS = 1024,
  parameter logic [XLEN-1:0] BASE_ADDR   = '0,
  parameter string           INIT_FILE   = "",
  parameter int unsigned     RSP_DEPTH   = 4
) (
  input logic               clk,
  input logic               rst,
  im_rom_responder_if.slave im_bus
);

  localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int unsigned CW = $clog2(RSP_DEPTH + 1);
  localparam int unsigned FW = IM_WORD_W + 2;

  logic [IM_WORD_W-1:0] rom_q [DEPTH_WORDS];
  logic [IM_WORD_W-1:0] rom_data_q;
  logic [CW-1:0]        credits_q, credits_d;
  logic                 arready_q;
  logic                 s1_valid_q;
  resp_e                s1_resp_q;
  logic [XLEN-1:0]      offset_s, index_s;
  resp_e                resp_s;
  logic                 ar_hs_s, r_hs_s;
  logic                 fifo_full_s, fifo_empty_s;
  logic [FW-1:0]        push_data_s, head_s;
  logic                 unused_s;

  initial begin
    for (int unsigned i = 0; i < DEPTH_WORDS; i++) rom_q[AW'(i)] = '0;
  end

  assign ar_hs_s  = im_bus.arvalid && arready_q;
  assign r_hs_s   = !fifo_empty_s && im_bus.rready;
  assign unused_s = ^{im_bus.arprot, offset_s[1:0], fifo_full_s};

  // Address decode; a subtraction that wraps is caught by the araddr < BASE_ADDR term.
  always_comb begin
    offset_s = im_bus.araddr - BASE_ADDR;
    index_s  = {2'b00, offset_s[XLEN-1:2]};
    if ((im_bus.araddr < BASE_ADDR) || (index_s >= XLEN'(DEPTH_WORDS))) begin
      resp_s = RESP_DECERR;
    end else if (im_bus.araddr[1:0] != 2'b00) begin
      resp_s = RESP_SLVERR;
    end else begin
      resp_s = RESP_OKAY;
    end
  end

  always_comb begin
    credits_d = credits_q;
    if (ar_hs_s && !r_hs_s)      credits_d = credits_q + CW'(1);
    else if (!ar_hs_s && r_hs_s) credits_d = credits_q - CW'(1);
    else                         credits_d = credits_q;
  end

  // Credits count every accepted read not yet returned, so arready reserves a FIFO slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      credits_q  <= CW'(0);
      arready_q  <= 1'b0;
      s1_valid_q <= 1'b0;
      s1_resp_q  <= RESP_OKAY;
    end else begin
      credits_q  <= credits_d;
      arready_q  <= (credits_d < CW'(RSP_DEPTH));
      s1_valid_q <= ar_hs_s;
      if (ar_hs_s) s1_resp_q <= resp_s;
    end
  end

  // Synchronous-read ROM port; the read is issued on the AR handshake edge.
  always_ff @(posedge clk) begin
    if (ar_hs_s) rom_data_q <= rom_q[index_s[AW-1:0]];
  end

  assign push_data_s = {(s1_resp_q == RESP_OKAY) ? rom_data_q : IM_WORD_W'(0), 2'(s1_resp_q)};

  sync_fifo #(
    .WIDTH(FW),
    .DEPTH(RSP_DEPTH)
  ) u_rsp_fifo (
    .clk    (clk),
    .rst    (rst),
    .push_i (s1_valid_q),
    .data_i (push_data_s),
    .pop_i  (r_hs_s),
    .full_o (fifo_full_s),
    .empty_o(fifo_empty_s),
    .head_o (head_s)
  );

  assign im_bus.arready = arready_q;
  assign im_bus.rvalid  = !fifo_empty_s;
  assign im_bus.rdata   = fifo_empty_s ? XLEN'(0) : XLEN'(head_s[FW-1:2]);
  assign im_bus.rresp   = fifo_empty_s ? RESP_OKAY : resp_e'(head_s[1:0]);

endmodule

// File: tb/tb_im_rom_responder.sv
// Scoreboard bench: two ROM responders (base 0 and base 0x100) with directed reads.
module tb_im_rom_responder;
  import im_pkg::*;

  typedef struct packed {
    logic [31:0] d;
    logic [1:0]  r;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  beat_t       exp0[$];
  beat_t       exp1[$];
  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] img [8];
  logic        held [2];
  beat_t       hb [2];

  always #5 clk = ~clk;

  im_rom_responder_if #(.XLEN(32)) bus0 ();
  im_rom_responder_if #(.XLEN(32)) bus1 ();

  im_rom_responder #(
    .XLEN(32), .DEPTH_WORDS(1024), .BASE_ADDR(32'h0), .INIT_FILE(""), .RSP_DEPTH(4)
  ) dut0 (.clk(clk), .rst(rst), .im_bus(bus0));

  im_rom_responder #(
    .XLEN(32), .DEPTH_WORDS(1024), .BASE_ADDR(32'h100), .INIT_FILE(""), .RSP_DEPTH(4)
  ) dut1 (.clk(clk), .rst(rst), .im_bus(bus1));

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic flag(input string name, input logic [63:0] act);
    n_vec++;
    n_err++;
    $display("FAIL %s: got %0h, expected nothing", name, act);
  endtask

  task automatic mon(input int s, input logic rv, input logic rr, input beat_t got);
    beat_t e;
    if (held[s]) begin
      check($sformatf("r%0d_hold_valid", s), 64'(rv), 64'd1);
      check($sformatf("r%0d_hold_beat", s), 64'(got), 64'(hb[s]));
    end
    if (rv === 1'b1 && rr === 1'b1) begin
      held[s] = 1'b0;
      if ((s == 0 && exp0.size() == 0) || (s == 1 && exp1.size() == 0)) begin
        flag($sformatf("r%0d_spurious_beat", s), 64'(got));
      end else begin
        if (s == 0) e = exp0.pop_front();
        else        e = exp1.pop_front();
        check($sformatf("r%0d_beat", s), 64'(got), 64'(e));
      end
    end else begin
      held[s] = (rv === 1'b1);
      hb[s]   = got;
    end
  endtask

  // Monitor: compares every R beat against the scoreboard, and checks holding while stalled.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        held[0] = 1'b0;
        held[1] = 1'b0;
      end else begin
        mon(0, bus0.rvalid, bus0.rready, {bus0.rdata, 2'(bus0.rresp)});
        mon(1, bus1.rvalid, bus1.rready, {bus1.rdata, 2'(bus1.rresp)});
      end
    end
  end

  task automatic issue(input int s, input logic [31:0] a, input logic [31:0] d,
                       input logic [1:0] r);
    int g;
    g = 0;
    if (s == 0) begin bus0.arvalid = 1'b1; bus0.araddr = a; end
    else        begin bus1.arvalid = 1'b1; bus1.araddr = a; end
    while (((s == 0) ? bus0.arready : bus1.arready) !== 1'b1 && g < 100) begin
      @(posedge clk); #1; g++;
    end
    if (g >= 100) begin
      flag("ar_timeout", 64'(a));
    end else begin
      @(posedge clk);
      if (s == 0) exp0.push_back({d, r});
      else        exp1.push_back({d, r});
      #1;
    end
    if (s == 0) bus0.arvalid = 1'b0;
    else        bus1.arvalid = 1'b0;
  endtask

  task automatic drain(input string name);
    int g;
    g = 0;
    while ((exp0.size() != 0 || exp1.size() != 0) && g < 200) begin
      @(posedge clk); #1; g++;
    end
    check(name, 64'(exp0.size() + exp1.size()), 64'd0);
    repeat (3) begin @(posedge clk); #1; end
  endtask

  // Keep ARs coming with rready low: exactly four accepts, then arready drops.
  task automatic credit_fill(input string tag);
    int   acc;
    logic hs;
    acc = 0;
    bus0.rready  = 1'b0;
    bus0.arvalid = 1'b1;
    for (int c = 0; c < 8; c++) begin
      bus0.araddr = 32'(acc) << 2;
      hs = bus0.arready;
      @(posedge clk);
      if (hs === 1'b1 && acc < 8) begin
        exp0.push_back({img[acc[2:0]], 2'b00});
        acc++;
      end
      #1;
    end
    bus0.arvalid = 1'b0;
    check({tag, "_accepts"}, 64'(acc), 64'd4);
    check({tag, "_arready_full"}, 64'(bus0.arready), 64'd0);
    repeat (3) begin @(posedge clk); #1; end
    bus0.rready = 1'b1;
    drain({tag, "_drain"});
    check({tag, "_arready_back"}, 64'(bus0.arready), 64'd1);
  endtask

  initial begin
    img = '{32'h00000013, 32'h00100093, 32'h00200113, 32'h00308193,
            32'h00410213, 32'h00518293, 32'h00620313, 32'h00728393};
    bus0.arvalid = 1'b0; bus0.araddr = 32'h0; bus0.arprot = 3'b000; bus0.rready = 1'b0;
    bus1.arvalid = 1'b0; bus1.araddr = 32'h0; bus1.arprot = 3'b101; bus1.rready = 1'b0;
    #1;
    for (int i = 0; i < 8; i++) begin
      dut0.rom_q[10'(i)] = img[i];
      dut1.rom_q[10'(i)] = img[i];
    end

    // Reset values, then release.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_arready", 64'(bus0.arready), 64'd0);
    check("rst_rvalid", 64'(bus0.rvalid), 64'd0);
    check("rst_rdata", 64'(bus0.rdata), 64'd0);
    check("rst_rresp", 64'(bus0.rresp), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rel_arready_before_edge", 64'(bus0.arready), 64'd0);
    @(negedge clk);
    check("rel_arready", 64'(bus0.arready), 64'd1);
    check("rel_rvalid", 64'(bus0.rvalid), 64'd0);

    // First read latency: handshake at edge k, rvalid visible after edge k+1.
    @(posedge clk); #1;
    bus1.rready  = 1'b1;
    bus0.arvalid = 1'b1;
    bus0.araddr  = 32'h0;
    @(posedge clk);
    exp0.push_back({32'h00000013, 2'b00});
    #1;
    bus0.arvalid = 1'b0;
    @(negedge clk);
    check("lat_after_k", 64'(bus0.rvalid), 64'd0);
    @(negedge clk);
    check("lat_after_k1", 64'(bus0.rvalid), 64'd1);
    @(posedge clk); #1;
    bus0.rready = 1'b1;
    drain("lat_drain");

    // Back-to-back reads with rready held high.
    for (int i = 0; i < 8; i++) begin
      check("b2b_arready", 64'(bus0.arready), 64'd1);
      issue(0, 32'(i) << 2, img[i], 2'b00);
    end
    drain("b2b_drain");

    credit_fill("credit");

    // Error responses and address boundaries.
    issue(0, 32'h00000002, 32'h0, 2'b10);
    issue(0, 32'h00001000, 32'h0, 2'b11);
    issue(0, 32'h00000FFC, 32'h0, 2'b00);
    issue(0, 32'hFFFFFFFC, 32'h0, 2'b11);
    issue(0, 32'h0000001C, 32'h00728393, 2'b00);
    issue(1, 32'h00000000, 32'h0, 2'b11);
    issue(1, 32'h00000100, 32'h00000013, 2'b00);
    issue(1, 32'h00000106, 32'h0, 2'b10);
    issue(1, 32'h000000FC, 32'h0, 2'b11);
    issue(1, 32'h0000011C, 32'h00728393, 2'b00);
    drain("err_drain");

    // Reset with three reads in flight: nothing stale may come out afterwards.
    bus0.rready = 1'b0;
    issue(0, 32'h0, img[0], 2'b00);
    issue(0, 32'h4, img[1], 2'b00);
    issue(0, 32'h8, img[2], 2'b00);
    rst = 1'b1;
    exp0.delete();
    exp1.delete();
    @(posedge clk);
    @(negedge clk);
    check("mid_rst_rvalid", 64'(bus0.rvalid), 64'd0);
    check("mid_rst_arready", 64'(bus0.arready), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    bus0.rready = 1'b1;
    repeat (6) begin @(posedge clk); #1; end
    check("post_rst_rvalid", 64'(bus0.rvalid), 64'd0);
    credit_fill("post_rst");

    // Simultaneous AR and R handshakes while three reads are outstanding.
    bus0.rready = 1'b0;
    issue(0, 32'h0, img[0], 2'b00);
    issue(0, 32'h4, img[1], 2'b00);
    issue(0, 32'h8, img[2], 2'b00);
    repeat (2) begin @(posedge clk); #1; end
    check("sim_arready_pre", 64'(bus0.arready), 64'd1);
    bus0.rready  = 1'b1;
    bus0.arvalid = 1'b1;
    bus0.araddr  = 32'hC;
    @(posedge clk);
    exp0.push_back({img[3], 2'b00});
    #1;
    bus0.rready  = 1'b0;
    bus0.arvalid = 1'b0;
    @(negedge clk);
    check("sim_arready_post", 64'(bus0.arready), 64'd1);
    @(posedge clk); #1;
    issue(0, 32'h10, img[4], 2'b00);
    check("sim_full", 64'(bus0.arready), 64'd0);
    bus0.rready = 1'b1;
    drain("sim_drain");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
